// File: rtl/mpatrol_input_ctrl.sv
// Moon Patrol player-input stage: PS/2 key latches merged with both joysticks, plus coin pulse.
// Optional coin stretching is compiled in with `define MPATROL_COIN_STRETCH_EN.
module mpatrol_input_ctrl #(
  parameter int unsigned COIN_CYCLES = 3000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [7:0]  joy1_out,
  output logic [7:0]  joy2_out,
  output logic        dbg_state
);

  typedef enum logic {ARM = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;
  logic   old_toggle;
  logic   key_ev;
  logic   nx;
  logic   pressed;

  // Held-key latches; k1/k2 bit order matches the joystick layout [5:0].
  logic [5:0] k1, k2;
  logic [1:0] k_st1, k_st2, k_coin;
  logic [5:0] wr1, wr2;
  logic [1:0] wr_st1, wr_st2, wr_coin;

  logic [6:0] j0_r, j1_r;
  logic [6:0] joy1_lo, joy2_lo;
  logic       start1, start2, coin_req, coin_bit;

  logic unused_inputs;
  assign unused_inputs = ^{joystick_0[15:7], joystick_1[15:7]};

  assign dbg_state = (state_q == RUN);
  assign pressed   = ps2_key[9];
  assign nx        = ~ps2_key[8];
  assign key_ev    = (state_q == RUN) && (ps2_key[10] != old_toggle);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ARM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ARM) state_d = RUN;
  end

  always_comb begin
    wr1     = '0;
    wr2     = '0;
    wr_st1  = '0;
    wr_st2  = '0;
    wr_coin = '0;
    if (key_ev) begin
      case (ps2_key[7:0])
        8'h74: wr1[0]     = 1'b1;
        8'h6B: wr1[1]     = 1'b1;
        8'h72: wr1[2]     = 1'b1;
        8'h75: wr1[3]     = 1'b1;
        8'h14: wr1[4]     = nx;
        8'h29: wr1[5]     = nx;
        8'h34: wr2[0]     = nx;
        8'h23: wr2[1]     = nx;
        8'h2B: wr2[2]     = nx;
        8'h2D: wr2[3]     = nx;
        8'h1C: wr2[4]     = nx;
        8'h1B: wr2[5]     = nx;
        8'h05: wr_st1[0]  = nx;
        8'h16: wr_st1[1]  = nx;
        8'h06: wr_st2[0]  = nx;
        8'h1E: wr_st2[1]  = nx;
        8'h2E: wr_coin[0] = nx;
        8'h36: wr_coin[1] = nx;
        default: ;
      endcase
    end
  end

  // The ARM cycle re-syncs old_toggle so a stale toggle level is never decoded.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_toggle <= 1'b0;
      k1         <= '0;
      k2         <= '0;
      k_st1      <= '0;
      k_st2      <= '0;
      k_coin     <= '0;
    end else begin
      if (state_q == ARM || key_ev) old_toggle <= ps2_key[10];
      k1     <= (k1 & ~wr1) | ({6{pressed}} & wr1);
      k2     <= (k2 & ~wr2) | ({6{pressed}} & wr2);
      k_st1  <= (k_st1 & ~wr_st1) | ({2{pressed}} & wr_st1);
      k_st2  <= (k_st2 & ~wr_st2) | ({2{pressed}} & wr_st2);
      k_coin <= (k_coin & ~wr_coin) | ({2{pressed}} & wr_coin);
    end
  end

  assign start1   = (|k_st1) | j0_r[6];
  assign start2   = (|k_st2) | j1_r[6];
  assign coin_req = (|k_coin) | start1 | start2;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      j0_r    <= '0;
      j1_r    <= '0;
      joy1_lo <= '0;
      joy2_lo <= '0;
    end else begin
      j0_r    <= joystick_0[6:0];
      j1_r    <= joystick_1[6:0];
      joy1_lo <= {start1, k1 | j0_r[5:0]};
      joy2_lo <= {start2, k2 | j1_r[5:0]};
    end
  end

`ifdef MPATROL_COIN_STRETCH_EN
  localparam logic [21:0] COIN_LOAD = 22'(COIN_CYCLES);

  logic [21:0] coin_cnt;
  logic        coin_req_d;

  // A rising request only loads an idle counter; there is no retrigger.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_cnt   <= '0;
      coin_req_d <= 1'b0;
    end else begin
      coin_req_d <= coin_req;
      if (coin_req && !coin_req_d && coin_cnt == '0) coin_cnt <= COIN_LOAD;
      else if (coin_cnt != '0)                       coin_cnt <= coin_cnt - 22'd1;
    end
  end

  assign coin_bit = (coin_cnt != '0);
`else
  logic unused_coin_cfg;
  assign unused_coin_cfg = (COIN_CYCLES == 0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) coin_bit <= 1'b0;
    else       coin_bit <= coin_req;
  end
`endif

  assign joy1_out = {coin_bit, joy1_lo};
  assign joy2_out = {1'b0, joy2_lo};

endmodule

// File: tb/tb_mpatrol_input_ctrl.sv
// Bench for mpatrol_input_ctrl: per-key behavioural model, every-cycle compare, directed pins.
module tb_mpatrol_input_ctrl;

  localparam int COIN = 10;

`ifdef MPATROL_COIN_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;
  logic [7:0]  joy1_out, joy2_out;
  logic        dbg_state;

  mpatrol_input_ctrl #(.COIN_CYCLES(COIN)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .joy1_out   (joy1_out),
    .joy2_out   (joy2_out),
    .dbg_state  (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        key_held [0:511];
  bit        m_run;
  bit        m_old;
  bit [15:0] mj0, mj1;
  bit        m_req_prev;
  int        m_cnt;
  logic [7:0] e1 = '0, e2 = '0;

  function automatic int kidx(input bit ext, input bit [7:0] c);
    if (c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74) return int'(c);
    return int'({ext, c});
  endfunction

  function automatic bit k(input bit [7:0] c);
    return key_held[int'(c)];
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    bit s1, s2, req, coin;
    bit [5:0] p1, p2;
    if (reset) begin
      for (int i = 0; i < 512; i++) key_held[i] = 1'b0;
      m_run = 0; m_old = 0; mj0 = '0; mj1 = '0; m_req_prev = 0; m_cnt = 0;
      e1 = '0; e2 = '0;
    end else begin
      // outputs after this edge reflect key/joystick state held since the previous edge
      s1  = k(8'h05) | k(8'h16) | mj0[6];
      s2  = k(8'h06) | k(8'h1E) | mj1[6];
      p1  = {k(8'h29), k(8'h14), k(8'h75), k(8'h72), k(8'h6B), k(8'h74)} | mj0[5:0];
      p2  = {k(8'h1B), k(8'h1C), k(8'h2D), k(8'h2B), k(8'h23), k(8'h34)} | mj1[5:0];
      req = k(8'h2E) | k(8'h36) | s1 | s2;
      if (STRETCH) begin
        if (req && !m_req_prev && m_cnt == 0) m_cnt = COIN;
        else if (m_cnt > 0) m_cnt--;
        coin = (m_cnt > 0);
      end else begin
        coin = req;
      end
      m_req_prev = req;
      e1 = {coin, s1, p1};
      e2 = {1'b0, s2, p2};
      mj0 = joystick_0;
      mj1 = joystick_1;
      if (!m_run) begin
        m_old = ps2_key[10];
        m_run = 1;
      end else if (ps2_key[10] != m_old) begin
        m_old = ps2_key[10];
        key_held[kidx(ps2_key[8], ps2_key[7:0])] = ps2_key[9];
      end
    end
  end

  always @(negedge clk_sys) begin
    if (cmp_en) begin
      check("model_joy1", joy1_out, e1);
      check("model_joy2", joy2_out, e2);
      check("model_fsm", dbg_state, m_run);
    end
  end

  // ---------------- drivers ----------------
  task automatic key_event(input bit ext, input bit [7:0] code, input bit pr);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  bit [7:0] codes [0:19] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h2D, 8'h2B, 8'h23, 8'h34,
                              8'h1B, 8'h1C, 8'h05, 8'h16, 8'h06, 8'h1E, 8'h2E, 8'h36, 8'h1A, 8'h5A};

  initial begin
    int s_cnt, c_cnt, first;

    ps2_key = 11'h400;
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    check("run_after_arm", dbg_state, 1'b1);
    check("reset_joy1", joy1_out, 8'h00);
    check("reset_joy2", joy2_out, 8'h00);

    // jump key press then release
    key_event(1'b0, 8'h29, 1'b1);
    cycles(1);
    check("jump_lat1", joy1_out, 8'h00);
    cycles(1);
    check("jump_press", joy1_out, 8'h20);
    key_event(1'b0, 8'h29, 1'b0);
    cycles(2);
    check("jump_release", joy1_out, 8'h00);

    // extended up key OR joystick up
    key_event(1'b1, 8'h75, 1'b1);
    joystick_0[3] = 1'b1;
    cycles(2);
    check("up_both", joy1_out, 8'h08);
    key_event(1'b1, 8'h75, 1'b0);
    cycles(5);
    check("up_joy_hold", joy1_out, 8'h08);
    joystick_0[3] = 1'b0;
    cycles(1);
    check("up_drop_lat", joy1_out, 8'h08);
    cycles(1);
    check("up_drop", joy1_out, 8'h00);

    // player-2 key lands in joy2 only
    key_event(1'b0, 8'h1C, 1'b1);
    cycles(2);
    check("p2_fire", joy2_out, 8'h10);
    key_event(1'b0, 8'h1C, 1'b0);
    cycles(2);

    // joystick start held 50 cycles
    joystick_0[6] = 1'b1;
    s_cnt = 0; c_cnt = 0; first = -1;
    for (int i = 0; i < 70; i++) begin
      cycles(1);
      if (joy1_out[6]) s_cnt++;
      if (joy1_out[7]) begin
        c_cnt++;
        if (first < 0) first = i;
      end
      if (i == 49) joystick_0[6] = 1'b0;
    end
    check("start_len", s_cnt, 50);
    check("coin_len1", c_cnt, STRETCH ? COIN : 50);
    check("coin_first", first, 1);

    // re-press for 20 cycles
    joystick_0[6] = 1'b1;
    c_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (joy1_out[7]) c_cnt++;
      if (i == 19) joystick_0[6] = 1'b0;
    end
    check("coin_len2", c_cnt, STRETCH ? COIN : 20);

    // coin key held 50 cycles
    key_event(1'b0, 8'h2E, 1'b1);
    c_cnt = 0; first = -1;
    for (int i = 0; i < 70; i++) begin
      cycles(1);
      if (joy1_out[7]) begin
        c_cnt++;
        if (first < 0) first = i;
      end
      if (i == 49) key_event(1'b0, 8'h2E, 1'b0);
    end
    check("coinkey_len", c_cnt, STRETCH ? COIN : 50);
    check("coinkey_first", first, 1);

    // reset three cycles into a pulse, then a key event during ARM
    joystick_1[6] = 1'b1;
    cycles(5);
    check("pre_reset_coin", joy1_out[7], 1'b1);
    @(posedge clk_sys);
    #2 reset = 1'b1;
    #1 check("reset_async_joy1", joy1_out, 8'h00);
    check("reset_async_joy2", joy2_out, 8'h00);
    joystick_1 = '0;
    cycles(2);
    reset = 1'b0;
    key_event(1'b0, 8'h29, 1'b1);
    cycles(3);
    check("arm_absorb", joy1_out, 8'h00);
    key_event(1'b0, 8'h29, 1'b0);
    cycles(2);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0)
        key_event($urandom_range(0, 3) == 0, codes[$urandom_range(0, 19)], $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) joystick_0 = 16'($urandom);
      if ($urandom_range(0, 9) == 0) joystick_1 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        joystick_0 = '0;
        joystick_1 = '0;
      end
      cycles(1);
    end

    cycles(2);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpatrol_input_ctrl.md
# mpatrol_input_ctrl

Player-input conditioning stage between `hps_io` and the Moon Patrol game core. It decodes PS/2 key events into held-key latches and merges them with both MiSTer joysticks. It stretches coin requests into a fixed-length coin pulse and presents the two 8-bit active-high control bytes the core's `JOY`/`JOY2` ports consume. Runs entirely in the `clk_sys` (30 MHz) domain.

## Interface
Parameters:
- `COIN_CYCLES`, 3000000: coin pulse length in `clk_sys` cycles (100 ms); must be ≥1 and < 2^22.

Ports:
- `clk_sys`  in  1  system clock (30 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  `[10]` event toggle, `[9]` pressed, `[8]` extended flag, `[7:0]` scan code.
- `joystick_0`  in  16  player 1 pad: `[0]` right, `[1]` left, `[2]` down, `[3]` up, `[4]` fire, `[5]` jump, `[6]` start.
- `joystick_1`  in  16  player 2 pad, same layout.
- `joy1_out`  out  8  `{coin, start1, jump, fire, up, down, left, right}`.
- `joy2_out`  out  8  `{1'b0, start2, jump2, fire2, up2, down2, left2, right2}`.

## Operation
- Toggle FSM with states ARM and RUN.
  - Reset enters ARM.
  - In ARM, the first clock after reset release copies `ps2_key[10]` into `old_toggle`, decodes nothing, and moves to RUN.
  - In RUN, a key event is `ps2_key[10] != old_toggle`. On each event, `old_toggle` takes the new value and the matching latch is written with `ps2_key[9]`.
- Key map. The `X` in the arrow codes means the extended flag is don't-care; every other code requires `ps2_key[8]=0`.
  - Player 1: `X75` up, `X72` down, `X6B` left, `X74` right, `029` jump, `014` fire.
  - Player 2: `02D` up, `02B` down, `023` left, `034` right, `01B` jump, `01C` fire.
  - Start: `005`/`016` start1, `006`/`01E` start2.
  - Coin: `02E`, `036`.
  - Unmapped codes are ignored, but `old_toggle` still advances.
- Joystick inputs are registered once (`j0_r`, `j1_r`).
  - Player-1 byte = P1 latches OR `j0_r`.
  - Player-2 byte = P2 latches OR `j1_r`.
  - start1 = key latches OR `j0_r[6]`; start2 = key latches OR `j1_r[6]`.
- Coin request `coin_req` = coin-key latches OR start1 OR start2.
- Coin counter, 22 bits:
  - Loaded with `COIN_CYCLES` on the rising edge of `coin_req` (`coin_req & ~coin_req_d`).
  - Otherwise decrements when nonzero.
  - A rising edge while the counter is nonzero is ignored; there is no retrigger.
  - A new pulse requires `coin_req` to fall and rise again after the counter expires.
  - `joy1_out[7]` = (counter != 0).
- `joy2_out[7]` is constant 0.
- All outputs are registered.

## Timing
- Reset (async assert):
  - All key latches, `j0_r`, `j1_r`, `coin_req_d`, the counter, `joy1_out` and `joy2_out` clear to 0.
  - `old_toggle` clears to 0 and the FSM enters ARM.
- Latency:
  - Key event sampled at edge k: latch updates at k, output bit updates at k+1.
  - Joystick change sampled at edge j: `j*_r` updates at j, output updates at j+1.
  - Coin: counter loads on the same edge as start/coin latch output would update. `coin` is high for exactly `COIN_CYCLES` edges.
- Simultaneous events:
  - Key and joystick asserting the same bit in the same cycle: the outputs are an OR, so the bit is held until both release.
  - Press and release of the same key are separate toggle events and are never coincident.
- Reset mid-pulse: the counter is cleared immediately and coin drops asynchronously.
- A toggle edge arriving during ARM is absorbed and not decoded.
- Release of a key never pressed writes 0, with no side effect.

## Configuration
- `MPATROL_COIN_STRETCH_EN`
  - Defined: the coin counter and edge detector above are compiled in.
  - Undefined: the counter logic is removed and `joy1_out[7]` is the registered `coin_req`, a level that follows the sources with the same 2-cycle latency. `COIN_CYCLES` is unused.

## Test plan
- Reset released with `ps2_key[10]=1` → no latch set, FSM in RUN after 1 clock, both outputs `8'h00`.
- Toggle with `ps2_key=11'h?_029` pressed (`[9]=1`) → `joy1_out=8'h20` two edges after the event; toggle with `[9]=0` → `8'h00`.
- Extended `11'h1_75` pressed and `joystick_0[3]=1` together; release key only → `joy1_out[3]` stays 1 until `joystick_0[3]` drops, then 0 two edges later.
- With `COIN_CYCLES=10` and the macro defined: `joystick_0[6]` held 50 cycles → `joy1_out[6]` high for 50 cycles, `joy1_out[7]` high exactly 10 cycles, no second pulse; release and re-press → a second 10-cycle pulse.
- Assert `reset` 3 cycles into a coin pulse → `joy1_out` is `8'h00` immediately; key event during the ARM cycle is not decoded.
- Macro undefined: coin key `02E` held 50 cycles → `joy1_out[7]` high 50 cycles, starting 2 edges after the press.
